// File: rtl/calc_seq.sv
// calc_seq: signed WIDTH-bit accumulator calculator with a multi-cycle shift-add
// multiply, optional saturation and a DEPTH-entry circular undo history.
module calc_seq #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [WIDTH-1:0]           sw,
    input  logic                       btnl,
    input  logic                       btnc,
    input  logic                       btnr,
    input  logic                       btnd,
    input  logic                       btnu,
    output logic [WIDTH-1:0]           led,
    output logic                       ovf,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_UNDO = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    typedef struct packed {
        logic [WIDTH-1:0] acc;
        logic             ovf;
    } hist_t;

    state_t state, state_n;
    logic   btnd_q, btnu_q;
    logic   exec, clr;
    logic [2:0] op;
    logic [WIDTH-1:0] acc;

    hist_t          hist_mem [DEPTH];
    logic [PW-1:0]  wr_ptr, ptr_inc, ptr_dec;

    logic [2*WIDTH-1:0] m_cand, m_prod, m_add, prod_fin, prod_s;
    logic [WIDTH-1:0]   m_plier, acc_mag, sw_mag, mul_res;
    logic [WIDTH:0]     mul_hi;
    logic [SHW-1:0]     m_cnt;
    logic               m_neg, m_last, mul_ovf;

    logic [WIDTH:0]   sum_x, dif_x;
    logic [WIDTH-1:0] asr_res, commit_acc;
    logic             commit_ovf, commit, push, pop, cap;
    logic             sum_ovf, dif_ovf;

    assign exec = btnd & ~btnd_q;
    assign clr  = btnu & ~btnu_q;
    assign op   = {btnl, btnc, btnr};
    assign led  = acc;
    assign busy = (state == S_MUL);

    assign ptr_inc = (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
    assign ptr_dec = (wr_ptr == '0) ? PW'(DEPTH-1) : wr_ptr - 1'b1;

    // One extra sign bit exposes both the overflow and the true sign of the result.
    assign sum_x   = {acc[WIDTH-1], acc} + {sw[WIDTH-1], sw};
    assign dif_x   = {acc[WIDTH-1], acc} - {sw[WIDTH-1], sw};
    assign sum_ovf = sum_x[WIDTH] ^ sum_x[WIDTH-1];
    assign dif_ovf = dif_x[WIDTH] ^ dif_x[WIDTH-1];
    assign asr_res = $signed(acc) >>> sw[SHW-1:0];

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH:0] v, input logic ov);
        if (SATURATE != 0 && ov) return v[WIDTH] ? MINV : MAXV;
        return v[WIDTH-1:0];
    endfunction

    // Multiply runs on magnitudes; the most negative value still fits as unsigned.
    assign acc_mag  = acc[WIDTH-1] ? (~acc + 1'b1) : acc;
    assign sw_mag   = sw[WIDTH-1] ? (~sw + 1'b1) : sw;
    assign m_add    = m_plier[0] ? m_cand : '0;
    assign prod_fin = m_prod + m_add;
    assign prod_s   = m_neg ? (~prod_fin + 1'b1) : prod_fin;
    assign mul_hi   = prod_s[2*WIDTH-1:WIDTH-1];
    assign mul_ovf  = ~((&mul_hi) | ~(|mul_hi));
    assign mul_res  = (SATURATE != 0 && mul_ovf) ? (m_neg ? MINV : MAXV) : prod_s[WIDTH-1:0];
    assign m_last   = (m_cnt == SHW'(WIDTH-1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n    = state;
        cap        = 1'b0;
        commit     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        commit_acc = acc;
        commit_ovf = ovf;
        if (clr) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exec) begin
                        case (op)
                            OP_ADD: begin
                                commit = 1'b1; push = 1'b1;
                                commit_acc = clamp(sum_x, sum_ovf);
                                commit_ovf = sum_ovf;
                            end
                            OP_SUB: begin
                                commit = 1'b1; push = 1'b1;
                                commit_acc = clamp(dif_x, dif_ovf);
                                commit_ovf = dif_ovf;
                            end
                            OP_AND: begin
                                commit = 1'b1; push = 1'b1;
                                commit_acc = acc & sw; commit_ovf = 1'b0;
                            end
                            OP_OR: begin
                                commit = 1'b1; push = 1'b1;
                                commit_acc = acc | sw; commit_ovf = 1'b0;
                            end
                            OP_XOR: begin
                                commit = 1'b1; push = 1'b1;
                                commit_acc = acc ^ sw; commit_ovf = 1'b0;
                            end
                            OP_ASR: begin
                                commit = 1'b1; push = 1'b1;
                                commit_acc = asr_res; commit_ovf = 1'b0;
                            end
                            OP_MUL: begin
                                cap     = 1'b1;
                                state_n = S_MUL;
                            end
                            OP_UNDO: begin
                                if (hist_cnt != '0) begin
                                    commit = 1'b1; pop = 1'b1;
                                    commit_acc = hist_mem[ptr_dec].acc;
                                    commit_ovf = hist_mem[ptr_dec].ovf;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (m_last) begin
                        state_n    = S_IDLE;
                        commit     = 1'b1;
                        push       = 1'b1;
                        commit_acc = mul_res;
                        commit_ovf = mul_ovf;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btnd_q   <= 1'b0;
            btnu_q   <= 1'b0;
            acc      <= '0;
            ovf      <= 1'b0;
            hist_cnt <= '0;
            wr_ptr   <= '0;
            m_cand   <= '0;
            m_prod   <= '0;
            m_plier  <= '0;
            m_neg    <= 1'b0;
            m_cnt    <= '0;
        end else begin
            btnd_q <= btnd;
            btnu_q <= btnu;
            if (clr) begin
                acc      <= '0;
                ovf      <= 1'b0;
                hist_cnt <= '0;
                wr_ptr   <= '0;
            end else begin
                if (cap) begin
                    m_cand  <= {{WIDTH{1'b0}}, acc_mag};
                    m_plier <= sw_mag;
                    m_prod  <= '0;
                    m_neg   <= acc[WIDTH-1] ^ sw[WIDTH-1];
                    m_cnt   <= '0;
                end else if (state == S_MUL) begin
                    m_prod  <= prod_fin;
                    m_cand  <= m_cand << 1;
                    m_plier <= m_plier >> 1;
                    m_cnt   <= m_cnt + 1'b1;
                end
                if (commit) begin
                    acc <= commit_acc;
                    ovf <= commit_ovf;
                end
                if (push) begin
                    wr_ptr <= ptr_inc;
                    if (hist_cnt != CW'(DEPTH)) hist_cnt <= hist_cnt + 1'b1;
                end else if (pop) begin
                    wr_ptr   <= ptr_dec;
                    hist_cnt <= hist_cnt - 1'b1;
                end
            end
        end
    end

    // History storage needs no reset; hist_cnt qualifies every read.
    always_ff @(posedge clk) begin
        if (!clr && push) hist_mem[wr_ptr] <= '{acc: acc, ovf: ovf};
    end

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq: table of single-cycle ops plus hand-written
// sequences for multiply latency, saturation, history wrap, clear and reset.
module tb_calc_seq;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] sw = '0;
    logic        btnl = 1'b0, btnc = 1'b0, btnr = 1'b0, btnd = 1'b0, btnu = 1'b0;
    logic [15:0] led0, led1;
    logic        ovf0, ovf1, busy0, busy1;
    logic [2:0]  cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           XOR_ = 3'b100, MUL = 3'b101, ASR = 3'b110, UNDO = 3'b111;

    calc_seq #(.WIDTH(16), .DEPTH(4), .SATURATE(0)) dut (
        .clk(clk), .resetn(resetn), .sw(sw), .btnl(btnl), .btnc(btnc), .btnr(btnr),
        .btnd(btnd), .btnu(btnu), .led(led0), .ovf(ovf0), .busy(busy0), .hist_cnt(cnt0));

    calc_seq #(.WIDTH(16), .DEPTH(4), .SATURATE(1)) dut_s (
        .clk(clk), .resetn(resetn), .sw(sw), .btnl(btnl), .btnc(btnc), .btnr(btnr),
        .btnd(btnd), .btnu(btnu), .led(led1), .ovf(ovf1), .busy(busy1), .hist_cnt(cnt1));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] b;
        logic [15:0] led;
        logic        ovf;
        logic [2:0]  cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [15:0] b);
        @(negedge clk);
        {btnl, btnc, btnr} = o;
        sw   = b;
        btnd = 1'b1;
        @(negedge clk);
        btnd = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        btnu = 1'b1;
        @(negedge clk);
        btnu = 1'b0;
    endtask

    task automatic do_mul(input logic [15:0] b);
        do_op(MUL, b);
        repeat (16) @(negedge clk);
    endtask

    vec_t vecs[13];

    initial begin
        int busy_cycles;
        logic led_stable;

        vecs[0]  = '{ADD,  16'h7FFF, 16'h7FFF, 1'b0, 3'd1};
        vecs[1]  = '{ADD,  16'h0001, 16'h8000, 1'b1, 3'd2};
        vecs[2]  = '{UNDO, 16'h0000, 16'h7FFF, 1'b0, 3'd1};
        vecs[3]  = '{SUB,  16'hFFFF, 16'h8000, 1'b1, 3'd2};
        vecs[4]  = '{AND_, 16'hFFFF, 16'h8000, 1'b0, 3'd3};
        vecs[5]  = '{SUB,  16'h0001, 16'h7FFF, 1'b1, 3'd4};
        vecs[6]  = '{XOR_, 16'h00FF, 16'h7F00, 1'b0, 3'd4};
        vecs[7]  = '{OR_,  16'h000F, 16'h7F0F, 1'b0, 3'd4};
        vecs[8]  = '{ASR,  16'h0014, 16'h07F0, 1'b0, 3'd4};
        vecs[9]  = '{SUB,  16'h0800, 16'hFFF0, 1'b0, 3'd4};
        vecs[10] = '{ASR,  16'h0002, 16'hFFFC, 1'b0, 3'd4};
        vecs[11] = '{UNDO, 16'h0000, 16'hFFF0, 1'b0, 3'd3};
        vecs[12] = '{UNDO, 16'h0000, 16'h07F0, 1'b0, 3'd2};

        // Reset state
        #12;
        check("rst_led", 32'(led0), 32'h0);
        check("rst_ovf_busy_cnt", {ovf0, busy0, 29'(cnt0)}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Single-cycle ops table
        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].b);
            check($sformatf("vec%0d_led", i), 32'(led0), 32'(vecs[i].led));
            check($sformatf("vec%0d_ovf", i), 32'(ovf0), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_cnt", i), 32'(cnt0), 32'(vecs[i].cnt));
        end

        // Saturation on ADD/SUB
        do_clr();
        do_op(ADD, 16'h7FFF);
        do_op(ADD, 16'h0001);
        check("sat_add_led", 32'(led1), 32'h7FFF);
        check("sat_add_ovf", 32'(ovf1), 32'h1);
        do_clr();
        do_op(ADD, 16'h8000);
        do_op(SUB, 16'h0001);
        check("sat_sub_led", 32'(led1), 32'h8000);
        check("sat_sub_ovf", 32'(ovf1), 32'h1);

        // MUL latency, ignored exec during busy, latched operand
        do_clr();
        do_op(ADD, 16'hFFFD);
        @(negedge clk);
        {btnl, btnc, btnr} = MUL;
        sw   = 16'h0007;
        btnd = 1'b1;
        @(negedge clk);
        btnd = 1'b0;
        busy_cycles = 0;
        led_stable  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (busy0) busy_cycles++;
            if (led0 !== 16'hFFFD) led_stable = 1'b0;
            if (i == 2) begin {btnl, btnc, btnr} = ADD; sw = 16'h1234; end
            btnd = (i == 3 || i == 6);
            @(negedge clk);
        end
        btnd = 1'b0;
        check("mul_busy_cycles", 32'(busy_cycles), 32'd16);
        check("mul_led_hold", 32'(led_stable), 32'h1);
        check("mul_busy_end", 32'(busy0), 32'h0);
        check("mul_led", 32'(led0), 32'hFFEB);
        check("mul_ovf", 32'(ovf0), 32'h0);
        check("mul_cnt", 32'(cnt0), 32'd2);
        repeat (3) @(negedge clk);
        check("mul_no_late_op", 32'(led0), 32'hFFEB);

        // MUL overflow, wrap vs saturate
        do_clr();
        do_op(ADD, 16'h0100);
        do_mul(16'h0100);
        check("mul_ovf_wrap_led", 32'(led0), 32'h0000);
        check("mul_ovf_wrap_ovf", 32'(ovf0), 32'h1);
        check("mul_ovf_sat_led", 32'(led1), 32'h7FFF);
        check("mul_ovf_sat_ovf", 32'(ovf1), 32'h1);

        // History wrap
        do_clr();
        for (int i = 0; i < 6; i++) do_op(ADD, 16'h0001);
        check("wrap_led", 32'(led0), 32'd6);
        check("wrap_cnt", 32'(cnt0), 32'd4);
        for (int k = 0; k < 5; k++) begin
            do_op(UNDO, 16'h0000);
            check($sformatf("undo%0d_led", k), 32'(led0), (k < 4) ? 32'(5 - k) : 32'd2);
            check($sformatf("undo%0d_cnt", k), 32'(cnt0), (k < 4) ? 32'(3 - k) : 32'd0);
        end

        // Clear mid-MUL
        do_clr();
        do_op(ADD, 16'h0005);
        do_op(MUL, 16'h0003);
        repeat (4) @(negedge clk);
        btnu = 1'b1;
        @(negedge clk);
        check("clr_mul_led", 32'(led0), 32'h0);
        check("clr_mul_busy_cnt", {busy0, ovf0, 30'(cnt0)}, 32'h0);
        btnu = 1'b0;
        repeat (20) @(negedge clk);
        check("clr_mul_no_commit", {busy0, ovf0, cnt0, led0}, 32'h0);

        // Clear and execute together
        do_op(ADD, 16'h0009);
        @(negedge clk);
        {btnl, btnc, btnr} = ADD;
        sw   = 16'h0003;
        btnu = 1'b1;
        btnd = 1'b1;
        @(negedge clk);
        btnu = 1'b0;
        btnd = 1'b0;
        check("clr_exec_led", 32'(led0), 32'h0);
        check("clr_exec_cnt", 32'(cnt0), 32'h0);

        // Held execute triggers one op
        @(negedge clk);
        {btnl, btnc, btnr} = ADD;
        sw   = 16'h0002;
        btnd = 1'b1;
        repeat (50) @(negedge clk);
        btnd = 1'b0;
        check("hold_led", 32'(led0), 32'd2);
        check("hold_cnt", 32'(cnt0), 32'd1);

        // Asynchronous reset mid-MUL
        do_op(MUL, 16'h0003);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy0), 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_led", 32'(led0), 32'h0);
        check("async_rst_rest", {ovf0, busy0, 29'(cnt0)}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_seq.md
# calc_seq

Parametrised sequential calculator core with a WIDTH-bit signed accumulator. It executes one operation per press of the execute button and supports a multi-cycle shift-add multiply, an optional saturation mode and a DEPTH-entry undo history. It drives the LED bank directly and sits between the board button/switch inputs and the display. It is the parametrised successor to the single-cycle 16-bit accumulator calculator.

## Interface
- WIDTH, 16, accumulator/operand width (≥4)
- DEPTH, 4, undo history entries (≥1)
- SATURATE, 0, 1 = clamp signed overflow to max/min; 0 = wrap
- clk  input  1  single clock, all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- sw  input  WIDTH  signed operand B (shift amount uses sw[$clog2(WIDTH)-1:0])
- btnl, btnc, btnr  input  1 each  op select, code = {btnl,btnc,btnr}
- btnd  input  1  execute (rising-edge triggered)
- btnu  input  1  clear (rising-edge triggered)
- led  output  WIDTH  accumulator value, registered
- ovf  output  1  overflow of last committed op
- busy  output  1  multiply in progress
- hist_cnt  output  $clog2(DEPTH+1)  valid undo entries

Inputs are already synchronous to clk and debounced.

## Operation
- Edge detect: btnd_q and btnu_q registers, reset 0. exec = btnd & ~btnd_q, clr = btnu & ~btnu_q.
- Op codes:
  - 000 ADD: acc+sw
  - 001 SUB: acc−sw
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MUL: signed, multi-cycle
  - 110 ASR: acc >>> sw shift field
  - 111 UNDO
- Op code is sampled on the exec cycle only. Later changes to btnl/btnc/btnr or sw do not affect an op in flight. MUL latches sw at capture.
- FSM states: IDLE, MUL.
  - IDLE + exec + single-cycle op: commit at that edge.
  - IDLE + exec + MUL: go to MUL.
  - MUL: one shift-add step per cycle, WIDTH steps on magnitudes, sign applied at the end. Commit on the last step, then return to IDLE.
- exec while in MUL is ignored and not queued.
- clr has top priority in any state:
  - acc=0, ovf=0, hist_cnt=0, FSM to IDLE.
  - A MUL in flight is aborted.
  - An exec in the same cycle is discarded.
- Arithmetic:
  - ADD/SUB ovf = signed overflow of the WIDTH-bit result.
  - MUL ovf = true 2·WIDTH product does not fit in signed WIDTH.
  - Logic ops and ASR: ovf=0.
  - SATURATE=0: result is the low WIDTH bits.
  - SATURATE=1: on ovf, result = 2^(WIDTH−1)−1 if the true result is positive, −2^(WIDTH−1) if negative. ovf is still reported.
- History: circular buffer of DEPTH entries. Each committed non-UNDO op pushes the pre-op {acc,ovf}.
  - When hist_cnt==DEPTH, the oldest entry is overwritten and hist_cnt stays at DEPTH.
  - UNDO with hist_cnt>0 pops: acc and ovf are restored, hist_cnt−1.
  - UNDO with hist_cnt==0: no change, no push.
- Reset values: led=0, ovf=0, busy=0, hist_cnt=0, FSM IDLE, buffer pointers 0. Buffer contents need no reset.

## Timing
- Single-cycle op or UNDO: btnd first sampled high at edge N → led/ovf/hist_cnt updated at edge N.
- MUL captured at edge N:
  - busy=1 from edge N to edge N+WIDTH.
  - Result, ovf and push happen at edge N+WIDTH.
  - busy=0 after edge N+WIDTH.
  - Next exec is accepted from edge N+WIDTH+1.
- Holding btnd high for any duration triggers exactly one op. A new op requires btnd to be low for ≥1 cycle.
- resetn assertion takes effect immediately (asynchronous) in any state, including mid-MUL. Deassertion must be synchronous to clk (external).

## Test plan
- WIDTH=16, SATURATE=0:
  - acc=0x7FFF, sw=0x0001, ADD → led=0x8000, ovf=1, hist_cnt=1.
  - Then UNDO → led=0x7FFF, ovf=0, hist_cnt=0.
- SATURATE=1: acc=0x7FFF, sw=1, ADD → led=0x7FFF, ovf=1. acc=0x8000, sw=1, SUB → led=0x8000, ovf=1.
- MUL latency:
  - acc=−3, sw=7, exec at edge N → busy high for 16 cycles, led=0xFFEB (−21) at edge N+16, ovf=0.
  - acc=0x0100, sw=0x0100 → ovf=1, led=0x0000.
  - exec pulses during busy produce no change.
- History wrap, DEPTH=4: six ADD 1 from 0 (led=6, hist_cnt=4). Five UNDOs → led 5,4,3,2, then 2 unchanged with hist_cnt=0.
- Clear mid-MUL: btnu rises 5 cycles after MUL capture → led=0, busy=0, hist_cnt=0 next edge, no late commit. btnu and btnd rising together → clear only.
- btnd held 50 cycles with ADD, sw=2 → exactly one add. Assert resetn low mid-MUL → all outputs 0 immediately, without a clock edge.
